// File: rtl/pipeline_hazard_sequencer.sv
// Control-path sequencer for a 5-stage pipeline: carries decoded control bundles
// through ID/EX, EX/MEM and MEM/WB and resolves load-use, branch and memory-wait hazards.
module pipeline_hazard_sequencer #(
  parameter int MAX_WAIT = 15,
  parameter int REG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       id_wb,
  input  logic [2:0]       id_mem,
  input  logic [3:0]       id_ex,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             mem_zero,
  input  logic             mem_ready,
  output logic [1:0]       idex_wb,
  output logic [2:0]       idex_mem,
  output logic [3:0]       idex_ex,
  output logic [1:0]       exmem_wb,
  output logic [2:0]       exmem_mem,
  output logic [1:0]       memwb_wb,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             pc_src,
  output logic [1:0]       state,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LD_STALL = 2'd1,
    S_FLUSH    = 2'd2,
    S_MEM_WAIT = 2'd3
  } state_e;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [1:0]       idex_wb_q, idex_wb_d;
  logic [2:0]       idex_mem_q, idex_mem_d;
  logic [3:0]       idex_ex_q, idex_ex_d;
  logic [REG_W-1:0] idex_dst_q, idex_dst_d;
  logic [1:0]       exmem_wb_q, exmem_wb_d;
  logic [2:0]       exmem_mem_q, exmem_mem_d;
  logic [1:0]       memwb_wb_q, memwb_wb_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  logic mem_op, mw, br, lu, forced;

  assign mem_op = exmem_mem_q[1] | exmem_mem_q[0];
  assign mw     = mem_op & ~mem_ready & (wait_cnt_q < MAX_W);
  assign br     = exmem_mem_q[2] & mem_zero;
  assign lu     = idex_mem_q[1] & (idex_dst_q != '0) &
                  ((idex_dst_q == id_rs) | (idex_dst_q == id_rt));

  // A memory op still not ready after leaving MEM_WAIT can only be the wait limit expiring
  assign forced = (state_q == S_MEM_WAIT) & (state_d != S_MEM_WAIT) & mem_op & ~mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_RUN;
    if (mw)      state_d = S_MEM_WAIT;
    else if (br) state_d = S_FLUSH;
    else if (lu) state_d = S_LD_STALL;
  end

  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    pc_src     = 1'b0;
    if (rst_n) begin
      pc_write   = (state_d == S_RUN) | (state_d == S_FLUSH);
      ifid_write = pc_write;
      ifid_flush = (state_d == S_FLUSH);
      pc_src     = (state_d == S_FLUSH);
    end
  end

  always_comb begin
    idex_wb_d   = id_wb;
    idex_mem_d  = id_mem;
    idex_ex_d   = id_ex;
    idex_dst_d  = id_dst;
    exmem_wb_d  = idex_wb_q;
    exmem_mem_d = idex_mem_q;
    memwb_wb_d  = exmem_wb_q;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q | forced;
    case (state_d)
      S_LD_STALL: begin
        idex_wb_d  = '0;
        idex_mem_d = '0;
        idex_ex_d  = '0;
        idex_dst_d = '0;
      end
      S_FLUSH: begin
        idex_wb_d   = '0;
        idex_mem_d  = '0;
        idex_ex_d   = '0;
        idex_dst_d  = '0;
        exmem_wb_d  = '0;
        exmem_mem_d = '0;
      end
      S_MEM_WAIT: begin
        idex_wb_d   = idex_wb_q;
        idex_mem_d  = idex_mem_q;
        idex_ex_d   = idex_ex_q;
        idex_dst_d  = idex_dst_q;
        exmem_wb_d  = exmem_wb_q;
        exmem_mem_d = exmem_mem_q;
        memwb_wb_d  = '0;
        wait_cnt_d  = wait_cnt_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_wb_q   <= '0;
      idex_mem_q  <= '0;
      idex_ex_q   <= '0;
      idex_dst_q  <= '0;
      exmem_wb_q  <= '0;
      exmem_mem_q <= '0;
      memwb_wb_q  <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      idex_wb_q   <= idex_wb_d;
      idex_mem_q  <= idex_mem_d;
      idex_ex_q   <= idex_ex_d;
      idex_dst_q  <= idex_dst_d;
      exmem_wb_q  <= exmem_wb_d;
      exmem_mem_q <= exmem_mem_d;
      memwb_wb_q  <= memwb_wb_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign idex_wb     = idex_wb_q;
  assign idex_mem    = idex_mem_q;
  assign idex_ex     = idex_ex_q;
  assign exmem_wb    = exmem_wb_q;
  assign exmem_mem   = exmem_mem_q;
  assign memwb_wb    = memwb_wb_q;
  assign state       = state_d;
  assign mem_timeout = timeout_q;

endmodule
